// File: rtl/regbank_write_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbank_write_decoder_if : request handshake and register-bank write bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface regbank_write_decoder_if #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) ();
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic                bank_stall;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [7:0]          drop_cnt;

  modport master (
    output req_valid, req_addr, req_data, bank_stall,
    input  req_ready, wr_en, wr_data, drop_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, bank_stall,
    output req_ready, wr_en, wr_data, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regbank_write_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbank_write_decoder : 2-entry buffered, registered one-hot write decoder
// Optional FIFO bypass (latency 1) when REGBANK_DEC_BYPASS_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
module regbank_write_decoder #(
  parameter int ADDR_W        = 4,
  parameter int NUM_REGS      = 16,
  parameter int DATA_W        = 32,
  parameter int ZERO_REG_PROT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regbank_write_decoder_if.slave  bus
);

  localparam logic [ADDR_W:0] NUM_LIM = (ADDR_W+1)'(NUM_REGS);

  logic [ADDR_W-1:0]   addr_mem_q [2];
  logic [DATA_W-1:0]   data_mem_q [2];
  logic                wptr_q, wptr_d;
  logic                rptr_q, rptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [7:0]          drop_q, drop_d;

  logic                full, empty, push, pop, push_fifo, bypass, take, legal;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] onehot;

  // Ready is derived from registered occupancy only, so a same-cycle pop never frees a slot.
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign push  = bus.req_valid & ~full;
  assign pop   = ~bus.bank_stall & ~empty;

`ifdef REGBANK_DEC_BYPASS_EN
  assign bypass   = push & empty & ~bus.bank_stall;
  assign sel_addr = bypass ? bus.req_addr : addr_mem_q[rptr_q];
  assign sel_data = bypass ? bus.req_data : data_mem_q[rptr_q];
`else
  assign bypass   = 1'b0;
  assign sel_addr = addr_mem_q[rptr_q];
  assign sel_data = data_mem_q[rptr_q];
`endif

  assign push_fifo = push & ~bypass;
  assign take      = pop | bypass;

  always_comb begin
    legal = ({1'b0, sel_addr} < NUM_LIM);
    if ((ZERO_REG_PROT != 0) && (sel_addr == '0)) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = legal && ({1'b0, sel_addr} == (ADDR_W+1)'(i));
    end
  end

  always_comb begin
    wptr_d = wptr_q ^ push_fifo;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push_fifo} - {1'b0, pop};
  end

  // A stalled bank keeps the current write pending; otherwise each pulse lasts one cycle.
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    if (!bus.bank_stall) begin
      wr_en_d = '0;
      if (take) begin
        wr_data_d = sel_data;
        if (legal) begin
          wr_en_d = onehot;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_fifo) begin
      addr_mem_q[wptr_q] <= bus.req_addr;
      data_mem_q[wptr_q] <= bus.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      drop_q    <= 8'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.req_ready = ~full;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regbank_write_decoder : directed bench, 16-register and 12-register builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regbank_write_decoder;

`ifdef REGBANK_DEC_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_addr;
  logic [31:0] req_data;
  logic        bank_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regbank_write_decoder_if #(.ADDR_W(4), .NUM_REGS(16), .DATA_W(32)) ifa ();
  regbank_write_decoder_if #(.ADDR_W(4), .NUM_REGS(12), .DATA_W(32)) ifb ();

  assign ifa.req_valid  = req_valid;
  assign ifa.req_addr   = req_addr;
  assign ifa.req_data   = req_data;
  assign ifa.bank_stall = bank_stall;
  assign ifb.req_valid  = req_valid;
  assign ifb.req_addr   = req_addr;
  assign ifb.req_data   = req_data;
  assign ifb.bank_stall = bank_stall;

  regbank_write_decoder #(.ADDR_W(4), .NUM_REGS(16), .DATA_W(32), .ZERO_REG_PROT(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regbank_write_decoder #(.ADDR_W(4), .NUM_REGS(12), .DATA_W(32), .ZERO_REG_PROT(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] en_a;
    logic [11:0] en_b;
    logic [7:0]  drop_a;
    logic [7:0]  drop_b;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    tbl[0] = '{4'd1,  32'h1111_0001, 16'h0002, 12'h002, 8'd0, 8'd0};
    tbl[1] = '{4'd2,  32'h2222_0002, 16'h0004, 12'h004, 8'd0, 8'd0};
    tbl[2] = '{4'd3,  32'h3333_0003, 16'h0008, 12'h008, 8'd0, 8'd0};
    tbl[3] = '{4'd15, 32'hFFFF_000F, 16'h8000, 12'h000, 8'd0, 8'd1};
    tbl[4] = '{4'd0,  32'h0000_0A00, 16'h0000, 12'h000, 8'd1, 8'd2};
    tbl[5] = '{4'd12, 32'hCCCC_000C, 16'h1000, 12'h000, 8'd1, 8'd3};
    tbl[6] = '{4'd11, 32'hBBBB_000B, 16'h0800, 12'h800, 8'd1, 8'd3};

    // Reset held with a live request
    rst_n      = 1'b0;
    bank_stall = 1'b0;
    drive(1'b1, 4'd5, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_wr_en", 32'(ifa.wr_en), 32'h0);
    end
    check("rst_wr_data", ifa.wr_data, 32'h0);
    check("rst_drop", 32'(ifa.drop_cnt), 32'h0);
    drive(1'b0, 4'd0, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(ifa.req_ready), 32'h1);
    check("rst_no_write", 32'(ifa.wr_en), 32'h0);

    // Single write
    drive(1'b1, 4'd5, 32'hDEADBEEF);
    check("single_ready", 32'(ifa.req_ready), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      drive(1'b0, 4'd0, 32'h0);
      check($sformatf("single_en_k%0d", k), 32'(ifa.wr_en), (k == LAT) ? 32'h0020 : 32'h0);
      if (k == LAT) check("single_data", ifa.wr_data, 32'hDEADBEEF);
    end

    // Back-to-back stream including illegal addresses on either build
    for (int k = 0; k < 7 + LAT; k++) begin
      int j;
      if (k < 7) begin
        drive(1'b1, tbl[k].addr, tbl[k].data);
        check($sformatf("b2b_ready_%0d", k), 32'(ifa.req_ready), 32'h1);
      end else begin
        drive(1'b0, 4'd0, 32'h0);
      end
      tick();
      j = k - (LAT - 1);
      if (j >= 0 && j < 7) begin
        check($sformatf("b2b_en_a_%0d", j), 32'(ifa.wr_en), 32'(tbl[j].en_a));
        check($sformatf("b2b_en_b_%0d", j), 32'(ifb.wr_en), 32'(tbl[j].en_b));
        check($sformatf("b2b_data_%0d", j), ifa.wr_data, tbl[j].data);
        check($sformatf("b2b_drop_a_%0d", j), 32'(ifa.drop_cnt), 32'(tbl[j].drop_a));
        check($sformatf("b2b_drop_b_%0d", j), 32'(ifb.drop_cnt), 32'(tbl[j].drop_b));
      end
    end
    drive(1'b0, 4'd0, 32'h0);
    tick();
    check("b2b_idle", 32'(ifa.wr_en), 32'h0);

    // Stall: two accepts fill the FIFO, third waits
    bank_stall = 1'b1;
    drive(1'b1, 4'd4, 32'h4444_0004);
    check("stall_rdy0", 32'(ifa.req_ready), 32'h1);
    tick();
    drive(1'b1, 4'd6, 32'h6666_0006);
    check("stall_rdy1", 32'(ifa.req_ready), 32'h1);
    tick();
    drive(1'b1, 4'd7, 32'h7777_0007);
    check("stall_full", 32'(ifa.req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_en", 32'(ifa.wr_en), 32'h0);
      check("stall_still_full", 32'(ifa.req_ready), 32'h0);
    end
    bank_stall = 1'b0;
    tick();
    check("rel_en4", 32'(ifa.wr_en), 32'h0010);
    check("rel_data4", ifa.wr_data, 32'h4444_0004);
    check("rel_ready", 32'(ifa.req_ready), 32'h1);
    // Stall while a write is on the bus; it must stay presented
    bank_stall = 1'b1;
    tick();
    drive(1'b0, 4'd0, 32'h0);
    check("hold_en4", 32'(ifa.wr_en), 32'h0010);
    check("hold_data4", ifa.wr_data, 32'h4444_0004);
    check("hold_full", 32'(ifa.req_ready), 32'h0);
    bank_stall = 1'b0;
    tick();
    check("rel_en6", 32'(ifa.wr_en), 32'h0040);
    tick();
    check("rel_en7", 32'(ifa.wr_en), 32'h0080);
    check("rel_data7", ifa.wr_data, 32'h7777_0007);
    tick();
    check("rel_idle", 32'(ifa.wr_en), 32'h0);

    // Drop counter saturation
    drive(1'b1, 4'd0, 32'h0);
    for (int i = 0; i < 300; i++) tick();
    drive(1'b0, 4'd0, 32'h0);
    for (int i = 0; i < LAT + 1; i++) tick();
    check("sat_drop_a", 32'(ifa.drop_cnt), 32'd255);
    check("sat_drop_b", 32'(ifb.drop_cnt), 32'd255);
    check("sat_no_write", 32'(ifa.wr_en), 32'h0);

    // Reset during a stall with two queued requests
    bank_stall = 1'b1;
    drive(1'b1, 4'd9, 32'h9999_0009);
    tick();
    drive(1'b1, 4'd10, 32'hAAAA_000A);
    tick();
    drive(1'b0, 4'd0, 32'h0);
    check("mid_full", 32'(ifa.req_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    bank_stall = 1'b0;
    check("mid_rst_ready", 32'(ifa.req_ready), 32'h1);
    check("mid_rst_drop", 32'(ifa.drop_cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_no_write_%0d", i), 32'(ifa.wr_en), 32'h0);
    end
    check("mid_ready_after", 32'(ifa.req_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
